// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel arbitrating multiplexer feeding one registered output.
//
// Configuration macro:
//   RR_MUX_ARB_FIXED_PRIO_EN - when defined, the lowest requesting channel
//                              always wins and no priority pointer exists.
//                              When undefined (default), round-robin
//                              arbitration with a rotating priority pointer.
//
// Handshake (both sides): a word moves when valid & ready are both high at
// a rising clk edge. Valid must not depend on ready. Once raised, out_valid
// and out_data stay stable until the word is taken. in_ready is
// combinational from in_valid, out_ready, the FSM state and the pointer.
//
// The output register FSM state is exported on dbg_state (0 = EMPTY,
// 1 = FULL) so that checkers can observe it directly.

module rr_mux_arb #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  input  logic           out_ready,
  output logic [IW-1:0]  out_idx,
  output logic           dbg_state
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t          state;
  state_t          next_state;
  logic            load_en;
  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [N-1:0]    gnt_oh;
  logic            grant;
  logic [W-1:0]    sel_data;
  logic [IW-1:0]   cand;

`ifndef RR_MUX_ARB_FIXED_PRIO_EN
  localparam logic [IW:0]   N_EXT = (IW+1)'(N);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);

  logic [IW-1:0]   ptr;
  logic [IW:0]     cand_sum;
`endif

  // Output register FSM: register may accept a new word when empty or
  // when its current word is leaving this cycle.
  always_comb begin
    next_state = state;
    load_en    = 1'b0;
    case (state)
      ST_EMPTY: begin
        load_en = 1'b1;
      end
      ST_FULL: begin
        load_en = out_ready;
      end
      default: begin
        load_en = 1'b0;
      end
    endcase
    if (load_en) begin
      next_state = gnt_found ? ST_FULL : ST_EMPTY;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Winner search: scan channels starting at the priority position and
  // take the first one that is requesting.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
`ifndef RR_MUX_ARB_FIXED_PRIO_EN
    cand_sum  = '0;
`endif
    for (int k = 0; k < N; k++) begin
`ifdef RR_MUX_ARB_FIXED_PRIO_EN
      cand = IW'(k);
`else
      cand_sum = {1'b0, ptr} + (IW+1)'(k);
      if (cand_sum >= N_EXT) begin
        cand_sum = cand_sum - N_EXT;
      end
      cand = cand_sum[IW-1:0];
`endif
      if (!gnt_found && in_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Grant decode and data select; nothing is accepted while in reset.
  always_comb begin
    gnt_oh          = '0;
    gnt_oh[gnt_idx] = 1'b1;
    grant           = load_en & gnt_found & rst_n;
    in_ready        = grant ? gnt_oh : '0;
    sel_data        = in_data[int'(gnt_idx)*W +: W];
  end

  // Output data register: loads only on a grant, otherwise holds so the
  // last word stays visible even after the register drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_idx  <= '0;
    end else if (grant) begin
      out_data <= sel_data;
      out_idx  <= gnt_idx;
    end
  end

`ifndef RR_MUX_ARB_FIXED_PRIO_EN
  // Priority pointer: the channel after the winner becomes highest
  // priority, wrapping from N-1 back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
    end
  end
`endif

  // Status outputs taken straight from the FSM state.
  always_comb begin
    out_valid = (state == ST_FULL);
    dbg_state = state;
  end

endmodule

// File: doc/rr_mux_arb.md
RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 SHALL have parameter N, default 4, number of input channels (legal 2..16).
REQ-002 SHALL have parameter W, default 8, data width per channel (legal 1..64).
REQ-003 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: in_valid  input  N  per-channel request; bit i belongs to channel i.
REQ-006 SHALL have ports: in_data  input  N*W  channel i data in bits [i*W+W-1 : i*W].
REQ-007 SHALL have ports: in_ready  output  N  per-channel accept; transfer on channel i when in_valid[i] & in_ready[i].
REQ-008 SHALL have ports: out_valid  output  1  output register holds a word.
REQ-009 SHALL have ports: out_data  output  W  registered selected data.
REQ-010 SHALL have ports: out_ready  input  1  downstream accept; transfer when out_valid & out_ready.
REQ-011 SHALL have ports: out_idx  output  max(1,$clog2(N))  source channel of word in out_data.

Function
REQ-012 SHALL hold one output register with a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 SHALL define load_en = EMPTY | (FULL & out_ready).
REQ-014 SHALL, when load_en and any in_valid bit set, grant exactly one channel g; in_ready = one-hot(g) in that cycle, else in_ready = 0.
REQ-015 SHALL in_ready be combinational from in_valid, out_ready, state and pointer; no dependency of in_valid on in_ready is permitted upstream.
REQ-016 SHALL on a grant load out_data <= channel g data, out_idx <= g, state -> FULL at the next edge (latency 1 cycle).
REQ-017 SHALL on load_en with no in_valid set move state -> EMPTY; out_data and out_idx hold their last values.
REQ-018 SHALL in FULL with out_ready=0 hold out_data, out_idx, out_valid stable and drive in_ready=0.
REQ-019 SHALL sustain one transfer per cycle when out_ready=1 and requests are continuous.
REQ-020 SHALL round-robin arbitrate: priority pointer p (reset 0); winner is the first requesting channel scanning p, p+1, ... N-1, 0, ... p-1.
REQ-021 SHALL after a grant to g set p <= (g+1) mod N; g = N-1 wraps p to 0; p unchanged when no grant.
REQ-022 SHALL ignore in_data of non-granted channels; a channel deasserting in_valid before grant is simply not served.
REQ-023 SHALL guarantee each continuously requesting channel a grant within N grants.

Reset
REQ-024 SHALL on rst_n=0, asynchronously: state EMPTY, out_valid=0, out_data=0, out_idx=0, p=0, in_ready=0.
REQ-025 SHALL discard any held word on reset mid-operation; no transfer is reported while rst_n=0.
REQ-026 SHALL resume arbitration on the first rising clk edge after rst_n deasserts, starting from channel 0.

Configuration
REQ-027 SHALL honour macro RR_MUX_ARB_FIXED_PRIO_EN.
REQ-028 SHALL when RR_MUX_ARB_FIXED_PRIO_EN is defined use fixed priority: lowest requesting index wins, pointer p is not implemented, REQ-021/REQ-023 waived.
REQ-029 SHALL when RR_MUX_ARB_FIXED_PRIO_EN is undefined implement round-robin per REQ-020..REQ-023.

Verification
REQ-030 SHALL cover: N=4,W=8, all in_valid=1, data ch i=0x10+i, out_ready=1 -> out_idx sequence 0,1,2,3,0 on consecutive cycles, out_data 0x10,0x11,0x12,0x13,0x10.
REQ-031 SHALL cover: only ch2 valid data 0xA5, out_ready=0 for 3 cycles -> out_valid=1, out_data=0xA5 stable, in_ready=0000 until out_ready=1, then one transfer.
REQ-032 SHALL cover: ch3 granted (p wraps to 0), then ch0 and ch3 valid -> ch0 granted next.
REQ-033 SHALL cover: rst_n pulsed low mid-cycle while FULL with 0x5A -> out_valid=0, out_data=0x00 immediately without clock edge; first grant after release from ch0.
REQ-034 SHALL cover: RR_MUX_ARB_FIXED_PRIO_EN defined, ch1 and ch3 always valid, out_ready=1 -> out_idx=1 every cycle, ch3 never granted.
REQ-035 SHALL cover: no requests while FULL and out_ready=1 -> out_valid=0 next cycle, out_data retains last value.
